bp_be_mem_miss_handler: RTL and testbench

Miss and exception sequencer directly downstream of the memory pipe. It consumes the pipe's mem2-aligned status (TLB miss, cache miss, fault flags, fence.i) for the instruction retiring out of the memory pipe. It issues page-table-walk requests and waits for refills or the LCE to complete. It then requests a replay of the missing instruction, or reports a precise exception with RISC-V cause code and faulting address.

---
 rtl/bp_be_mem_miss_handler.sv | 203 ++++++++++++++++++++
 tb/tb_bp_be_mem_miss_handler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_mem_miss_handler.sv
// bp_be_mem_miss_handler
//   Miss/exception sequencer sitting behind the memory pipe. It takes the
//   mem2-aligned status of the instruction leaving the pipe, issues page-table
//   walks, waits for TLB refills or LCE completion of D$ misses, and then
//   either requests a replay of the instruction or raises a precise exception
//   (RISC-V mcause + mtval). A watchdog aborts any wait state that lasts too
//   long.
//
// Ports
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   flush_i                   pipeline flush, aborts pending replay/exception
//   mem2_*                    instruction status at mem2 (valid, pc, vaddr, store)
//   tlb_miss_v_i, cache_miss_v_i, fault_i   miss/fault flags for that instruction
//   ptw_ready_i, ptw_fill_v_i, ptw_page_fault_i   page-table walker handshake
//   cache_req_complete_i      LCE finished the D$ miss
//   replay_yumi_i             replay request consumed
//   stall_o                   block new memory issue while busy
//   ptw_miss_v_o/_vaddr_o/_store_o   walk request
//   replay_v_o, replay_pc_o   replay request
//   exc_v_o, exc_cause_o, exc_vaddr_o   one-cycle exception report
//   watchdog_o                one-cycle pulse when a wait state timed out
module bp_be_mem_miss_handler #(
  parameter int vaddr_width_p = 39,
  parameter int timeout_p     = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     mem2_v_i,
  input  logic [vaddr_width_p-1:0] mem2_pc_i,
  input  logic [vaddr_width_p-1:0] mem2_vaddr_i,
  input  logic                     mem2_store_i,
  input  logic                     tlb_miss_v_i,
  input  logic                     cache_miss_v_i,
  input  logic [5:0]               fault_i,
  input  logic                     ptw_ready_i,
  input  logic                     ptw_fill_v_i,
  input  logic                     ptw_page_fault_i,
  input  logic                     cache_req_complete_i,
  input  logic                     replay_yumi_i,
  output logic                     stall_o,
  output logic                     ptw_miss_v_o,
  output logic [vaddr_width_p-1:0] ptw_miss_vaddr_o,
  output logic                     ptw_miss_store_o,
  output logic                     replay_v_o,
  output logic [vaddr_width_p-1:0] replay_pc_o,
  output logic                     exc_v_o,
  output logic [3:0]               exc_cause_o,
  output logic [vaddr_width_p-1:0] exc_vaddr_o,
  output logic                     watchdog_o
);

  localparam logic [2:0] idle_s       = 3'd0;
  localparam logic [2:0] ptw_req_s    = 3'd1;
  localparam logic [2:0] ptw_wait_s   = 3'd2;
  localparam logic [2:0] ptw_drain_s  = 3'd3;
  localparam logic [2:0] cache_wait_s = 3'd4;
  localparam logic [2:0] replay_s     = 3'd5;

  localparam logic [15:0] timeout_lp = 16'(timeout_p - 1);

  logic [2:0]               state_r, state_n;
  logic [vaddr_width_p-1:0] pc_r, vaddr_r;
  logic                     store_r;
  logic [15:0]              cnt_r;
  logic                     exc_v_r, exc_v_n;
  logic [3:0]               exc_cause_r, exc_cause_n;
  logic [vaddr_width_p-1:0] exc_vaddr_r, exc_vaddr_n;
  logic                     watchdog_r, watchdog_n;
  logic                     capture;
  logic                     waiting;
  logic                     timeout;

  // fault_i = {ld_mis, ld_acc, ld_page, st_mis, st_acc, st_page}
  // misaligned beats page beats access.
  function automatic logic [3:0] fault_cause(input logic [5:0] f);
    logic [3:0] c;
    c = 4'd0;
    if      (f[5]) c = 4'd4;
    else if (f[2]) c = 4'd6;
    else if (f[3]) c = 4'd13;
    else if (f[0]) c = 4'd15;
    else if (f[4]) c = 4'd5;
    else if (f[1]) c = 4'd7;
    return c;
  endfunction

  assign waiting = (state_r == ptw_wait_s) || (state_r == ptw_drain_s)
                || (state_r == cache_wait_s);
  assign timeout = waiting && (cnt_r == timeout_lp);

  always_comb begin
    state_n     = state_r;
    exc_v_n     = 1'b0;
    exc_cause_n = exc_cause_r;
    exc_vaddr_n = exc_vaddr_r;
    watchdog_n  = 1'b0;
    capture     = 1'b0;
    case (state_r)
      idle_s: begin
        if (mem2_v_i && !flush_i) begin
          if (|fault_i) begin
            capture     = 1'b1;
            exc_v_n     = 1'b1;
            exc_cause_n = fault_cause(fault_i);
            exc_vaddr_n = mem2_vaddr_i;
          end else if (tlb_miss_v_i) begin
            capture = 1'b1;
            state_n = ptw_req_s;
          end else if (cache_miss_v_i) begin
            capture = 1'b1;
            state_n = cache_wait_s;
          end
        end
      end
      ptw_req_s: begin
        if (flush_i)          state_n = idle_s;
        else if (ptw_ready_i) state_n = ptw_wait_s;
      end
      ptw_wait_s: begin
        // A flush cannot cancel a walk already in flight; drain its fill,
        // unless that fill is arriving right now.
        if (flush_i) begin
          state_n = ptw_fill_v_i ? idle_s : ptw_drain_s;
        end else if (ptw_fill_v_i) begin
          if (ptw_page_fault_i) begin
            exc_v_n     = 1'b1;
            exc_cause_n = store_r ? 4'd15 : 4'd13;
            exc_vaddr_n = vaddr_r;
            state_n     = idle_s;
          end else begin
            state_n = replay_s;
          end
        end else if (timeout) begin
          watchdog_n = 1'b1;
          state_n    = idle_s;
        end
      end
      ptw_drain_s: begin
        if (ptw_fill_v_i) begin
          state_n = idle_s;
        end else if (timeout) begin
          watchdog_n = 1'b1;
          state_n    = idle_s;
        end
      end
      cache_wait_s: begin
        if (flush_i) begin
          state_n = idle_s;
        end else if (cache_req_complete_i) begin
          state_n = replay_s;
        end else if (timeout) begin
          watchdog_n = 1'b1;
          state_n    = idle_s;
        end
      end
      replay_s: begin
        if (flush_i || replay_yumi_i) state_n = idle_s;
      end
      default: state_n = idle_s;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r     <= idle_s;
      pc_r        <= '0;
      vaddr_r     <= '0;
      store_r     <= 1'b0;
      cnt_r       <= '0;
      exc_v_r     <= 1'b0;
      exc_cause_r <= '0;
      exc_vaddr_r <= '0;
      watchdog_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      exc_v_r     <= exc_v_n;
      exc_cause_r <= exc_cause_n;
      exc_vaddr_r <= exc_vaddr_n;
      watchdog_r  <= watchdog_n;
      if (capture) begin
        pc_r    <= mem2_pc_i;
        vaddr_r <= mem2_vaddr_i;
        store_r <= mem2_store_i;
      end
      // Any state change leaves the wait state, so the counter cannot wrap.
      if (state_n != state_r) cnt_r <= '0;
      else if (waiting)       cnt_r <= cnt_r + 16'd1;
    end
  end

  assign stall_o          = (state_r != idle_s);
  assign ptw_miss_v_o     = (state_r == ptw_req_s);
  assign ptw_miss_vaddr_o = vaddr_r;
  assign ptw_miss_store_o = store_r;
  assign replay_v_o       = (state_r == replay_s);
  assign replay_pc_o      = pc_r;
  assign exc_v_o          = exc_v_r;
  assign exc_cause_o      = exc_cause_r;
  assign exc_vaddr_o      = exc_vaddr_r;
  assign watchdog_o       = watchdog_r;

endmodule

// File: tb/tb_bp_be_mem_miss_handler.sv
// Testbench for bp_be_mem_miss_handler: directed stimulus pushes expected
// responses (exception, walk request, replay, watchdog) with their expected
// cycle into queues; a negedge monitor pops and compares them as the DUT
// presents them.
module tb_bp_be_mem_miss_handler;
  localparam int VW = 39;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush, mem2_v, mem2_store, tlb_miss, cache_miss;
  logic [VW-1:0] mem2_pc, mem2_vaddr;
  logic [5:0]    fault;
  logic          ptw_ready, ptw_fill, ptw_pf, cache_done, yumi;
  logic          stall, ptw_v, ptw_store, replay_v, exc_v, wd;
  logic [VW-1:0] ptw_vaddr, replay_pc, exc_vaddr;
  logic [3:0]    exc_cause;

  bp_be_mem_miss_handler #(.vaddr_width_p(VW), .timeout_p(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .mem2_v_i(mem2_v), .mem2_pc_i(mem2_pc), .mem2_vaddr_i(mem2_vaddr),
    .mem2_store_i(mem2_store), .tlb_miss_v_i(tlb_miss),
    .cache_miss_v_i(cache_miss), .fault_i(fault),
    .ptw_ready_i(ptw_ready), .ptw_fill_v_i(ptw_fill),
    .ptw_page_fault_i(ptw_pf), .cache_req_complete_i(cache_done),
    .replay_yumi_i(yumi), .stall_o(stall), .ptw_miss_v_o(ptw_v),
    .ptw_miss_vaddr_o(ptw_vaddr), .ptw_miss_store_o(ptw_store),
    .replay_v_o(replay_v), .replay_pc_o(replay_pc), .exc_v_o(exc_v),
    .exc_cause_o(exc_cause), .exc_vaddr_o(exc_vaddr), .watchdog_o(wd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] a; logic [63:0] b; int c; } exp_t;
  exp_t exc_q[$], ptw_q[$], rep_q[$], wd_q[$];

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b, input int c);
    exp_t e;
    e.a = a; e.b = b; e.c = c;
    return e;
  endfunction

  // Monitor: compares every presented response against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (exc_v) begin
        if (exc_q.size() == 0) chk("exc_unexpected", 64'(exc_v), 64'd0);
        else begin
          exp_t e;
          e = exc_q.pop_front();
          chk("exc_cause", 64'(exc_cause), e.a);
          chk("exc_vaddr", 64'(exc_vaddr), e.b);
          chk("exc_cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (ptw_v && ptw_ready) begin
        if (ptw_q.size() == 0) chk("ptw_unexpected", 64'(ptw_v), 64'd0);
        else begin
          exp_t e;
          e = ptw_q.pop_front();
          chk("ptw_vaddr", 64'(ptw_vaddr), e.a);
          chk("ptw_store", 64'(ptw_store), e.b);
          chk("ptw_cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (replay_v && yumi) begin
        if (rep_q.size() == 0) chk("replay_unexpected", 64'(replay_v), 64'd0);
        else begin
          exp_t e;
          e = rep_q.pop_front();
          chk("replay_pc", 64'(replay_pc), e.a);
          chk("replay_cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (wd) begin
        if (wd_q.size() == 0) chk("wd_unexpected", 64'(wd), 64'd0);
        else begin
          exp_t e;
          e = wd_q.pop_front();
          chk("wd_cycle", 64'(cyc), 64'(e.c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush = 0; mem2_v = 0; mem2_store = 0; tlb_miss = 0; cache_miss = 0;
    mem2_pc = '0; mem2_vaddr = '0; fault = '0;
    ptw_ready = 0; ptw_fill = 0; ptw_pf = 0; cache_done = 0; yumi = 0;
  endtask

  task automatic issue(input logic [VW-1:0] pc, input logic [VW-1:0] va,
                       input logic st, input logic tl, input logic cm,
                       input logic [5:0] f);
    mem2_v = 1; mem2_pc = pc; mem2_vaddr = va; mem2_store = st;
    tlb_miss = tl; cache_miss = cm; fault = f;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({stall, ptw_v, ptw_store, replay_v, exc_v, wd, exc_cause})
         | 64'(ptw_vaddr) | 64'(replay_pc) | 64'(exc_vaddr);
  endfunction

  initial begin
    int n;
    int c;
    clear_in();
    reset_n = 0;
    tick(); tick();
    chk("reset_outputs", all_out(), 64'd0);
    reset_n = 1;
    tick();

    // Load access fault
    c = cyc;
    issue(39'h200, 39'h1000, 0, 0, 0, 6'b010000);
    exc_q.push_back(mk(64'd5, 64'h1000, c + 1));
    tick(); clear_in();
    chk("fault_ld_stall_n1", 64'(stall), 64'd0);
    tick();
    chk("fault_ld_stall_n2", 64'(stall), 64'd0);

    // Store with misaligned+access+page: misaligned wins
    c = cyc;
    issue(39'h204, 39'h2004, 1, 0, 0, 6'b000111);
    exc_q.push_back(mk(64'd6, 64'h2004, c + 1));
    tick(); clear_in(); tick();

    // Load page vs access: page wins
    c = cyc;
    issue(39'h208, 39'h2100, 0, 1, 1, 6'b011000);
    exc_q.push_back(mk(64'd13, 64'h2100, c + 1));
    tick(); clear_in();
    chk("fault_beats_miss_stall", 64'(stall), 64'd0);
    tick();

    // Load TLB miss, ready low 3 cycles, fill, yumi after 2 cycles
    c = cyc;
    issue(39'h400, 39'h3008, 0, 1, 0, 6'b0);
    ptw_q.push_back(mk(64'h3008, 64'd0, c + 4));
    tick(); clear_in();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      ptw_ready = (i == 3);
      if (ptw_v) n++;
      tick();
    end
    ptw_ready = 0;
    chk("ptw_req_cycles", 64'(n), 64'd4);
    chk("ptw_req_low_after", 64'(ptw_v), 64'd0);
    ptw_fill = 1;
    tick(); ptw_fill = 0;
    chk("tlb_replay_v", 64'(replay_v), 64'd1);
    chk("tlb_replay_pc", 64'(replay_pc), 64'h400);
    tick(); tick();
    rep_q.push_back(mk(64'h400, 64'd0, cyc));
    yumi = 1;
    chk("tlb_stall_at_yumi", 64'(stall), 64'd1);
    tick(); yumi = 0;
    chk("tlb_stall_after_yumi", 64'(stall), 64'd0);

    // Store TLB miss, walk ends in page fault
    c = cyc;
    issue(39'h500, 39'h4010, 1, 1, 0, 6'b0);
    ptw_q.push_back(mk(64'h4010, 64'd1, c + 1));
    tick(); clear_in();
    ptw_ready = 1;
    tick(); ptw_ready = 0;
    ptw_fill = 1; ptw_pf = 1;
    exc_q.push_back(mk(64'd15, 64'h4010, c + 3));
    tick(); ptw_fill = 0; ptw_pf = 0;
    chk("ptw_pf_no_replay", 64'(replay_v), 64'd0);
    chk("ptw_pf_stall", 64'(stall), 64'd0);
    tick();

    // Flush during PTW_WAIT, fill arrives 5 cycles later
    c = cyc;
    issue(39'h600, 39'h5000, 0, 1, 0, 6'b0);
    ptw_q.push_back(mk(64'h5000, 64'd0, c + 1));
    tick(); clear_in();
    ptw_ready = 1;
    tick(); ptw_ready = 0;
    flush = 1;
    tick(); flush = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (stall) n++;
      ptw_fill = (i == 4);
      tick();
    end
    ptw_fill = 0;
    chk("drain_stall_cycles", 64'(n), 64'd5);
    chk("drain_stall_after_fill", 64'(stall), 64'd0);
    chk("drain_no_replay", 64'(replay_v), 64'd0);
    tick();

    // Flush in IDLE suppresses the event; mem2_v=0 inputs are ignored
    issue(39'h650, 39'h5500, 0, 1, 0, 6'b0);
    flush = 1;
    tick(); clear_in();
    chk("idle_flush_suppress", 64'(stall), 64'd0);
    mem2_v = 0; fault = 6'b100000; tlb_miss = 1;
    tick(); clear_in();
    chk("no_valid_ignored", 64'(stall), 64'd0);
    tick();

    // Cache miss, complete, immediate yumi
    c = cyc;
    issue(39'h900, 39'h7000, 0, 0, 1, 6'b0);
    tick(); clear_in();
    chk("cache_stall", 64'(stall), 64'd1);
    tick();
    cache_done = 1;
    tick(); cache_done = 0;
    rep_q.push_back(mk(64'h900, 64'd0, c + 3));
    yumi = 1;
    tick(); yumi = 0;
    chk("cache_done_idle", 64'(stall), 64'd0);
    tick();

    // Cache miss with no completion: watchdog after 8 cycles in CACHE_WAIT
    c = cyc;
    issue(39'h700, 39'h6000, 0, 0, 1, 6'b0);
    wd_q.push_back(mk(64'd0, 64'd0, c + 9));
    tick(); clear_in();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (stall) n++;
      tick();
    end
    chk("wd_stall_cycles", 64'(n), 64'd8);
    chk("wd_back_idle", 64'(stall), 64'd0);
    chk("wd_no_replay", 64'(replay_v), 64'd0);
    tick();

    // Reset asserted while in REPLAY
    issue(39'h800, 39'h8000, 0, 0, 1, 6'b0);
    tick(); clear_in();
    cache_done = 1;
    tick(); cache_done = 0;
    chk("pre_reset_replay_v", 64'(replay_v), 64'd1);
    chk("pre_reset_replay_pc", 64'(replay_pc), 64'h800);
    reset_n = 0;
    tick();
    chk("mid_replay_reset_outputs", all_out(), 64'd0);
    reset_n = 1;
    tick(); tick(); tick();

    chk("exc_q_drained", 64'(exc_q.size()), 64'd0);
    chk("ptw_q_drained", 64'(ptw_q.size()), 64'd0);
    chk("rep_q_drained", 64'(rep_q.size()), 64'd0);
    chk("wd_q_drained", 64'(wd_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
